// File: rtl/freq_measure_array.sv
// freq_measure_array: serial line loader feeding per-pixel square-wave
// generators, with a high/low/period measurement unit on each generated wave.
// Optional build macro FREQ_MEASURE_SATURATE_EN: run-length and period
// counters saturate at all-ones instead of wrapping.
//
// load/shift handshake: there is no valid/ready pair here; every cycle with
// load=0 shifts one bit in, and a cycle with load=1 copies the shift register
// to data_out while the shift register holds.
module freq_measure_array #(
  parameter int NUM_PIXELS   = 4,
  parameter int INPUT_BITS   = 8,
  parameter int COUNTER_BITS = 32,
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int LOW_FREQ     = 1_000,
  parameter int HIGH_FREQ    = 20_000_000
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 shift_in,
  input  logic                                 load,
  output logic [NUM_PIXELS*INPUT_BITS-1:0]     data_out,
  output logic [NUM_PIXELS-1:0]                freq_out,
  output logic [NUM_PIXELS*COUNTER_BITS-1:0]   time_high,
  output logic [NUM_PIXELS*COUNTER_BITS-1:0]   time_low,
  output logic [NUM_PIXELS*COUNTER_BITS-1:0]   period
);

  localparam int WIDTH    = NUM_PIXELS * INPUT_BITS;
  localparam int GEN_BITS = 32;

  // Half-period endpoints in clk cycles, resolved at elaboration.
  localparam logic [63:0] H_LOW      = 64'(CLOCK_FREQ / (2 * LOW_FREQ));
  localparam logic [63:0] H_HIGH_RAW = 64'(CLOCK_FREQ / (2 * HIGH_FREQ));
  localparam logic [63:0] H_HIGH     = (H_HIGH_RAW < 64'd1) ? 64'd1 : H_HIGH_RAW;
  localparam logic [63:0] H_SPAN     = H_LOW - H_HIGH;
  localparam logic [63:0] MAXV       = (64'd1 << INPUT_BITS) - 64'd1;

  localparam logic [GEN_BITS-1:0]     GEN_ONE = {{(GEN_BITS-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_BITS-1:0] RUN_ONE = {{(COUNTER_BITS-1){1'b0}}, 1'b1};
`ifdef FREQ_MEASURE_SATURATE_EN
  localparam logic [COUNTER_BITS-1:0] RUN_MAX = '1;
`endif

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  // Shift stage: shift when idle, transfer to data_out on load.
  always_comb begin
    sr_d       = sr_q;
    data_out_d = data_out_q;
    if (load) begin
      data_out_d = sr_q;
    end else begin
      sr_d = {sr_q[WIDTH-2:0], shift_in};
    end
  end

  // Shift stage registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q       <= '0;
      data_out_q <= '0;
    end else begin
      sr_q       <= sr_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

  for (genvar g = 0; g < NUM_PIXELS; g++) begin : g_pix
    logic [INPUT_BITS-1:0]   pix;
    logic [63:0]             half_m1;
    logic [GEN_BITS-1:0]     cnt_q, cnt_d;
    logic                    freq_q, freq_d;
    logic                    prev_q, seen_q, seen_d;
    logic                    edge_det;
    logic [COUNTER_BITS-1:0] run_q, run_d, run_inc;
    logic [COUNTER_BITS-1:0] th_q, th_d, tl_q, tl_d, per_q, per_d, per_sum;
`ifdef FREQ_MEASURE_SATURATE_EN
    logic [COUNTER_BITS:0]   per_wide;
`endif

    assign pix = data_out_q[g*INPUT_BITS +: INPUT_BITS];

    // Generator and measurement next-state; the new pixel value is compared
    // against the running count without clearing it.
    always_comb begin
      half_m1  = H_LOW - ((H_SPAN * 64'(pix)) / MAXV) - 64'd1;
      cnt_d    = cnt_q + GEN_ONE;
      freq_d   = freq_q;
      seen_d   = seen_q;
      th_d     = th_q;
      tl_d     = tl_q;
      per_d    = per_q;
      edge_det = (freq_q != prev_q);
`ifdef FREQ_MEASURE_SATURATE_EN
      run_inc  = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
      per_wide = {1'b0, th_q} + {1'b0, run_q};
      per_sum  = per_wide[COUNTER_BITS] ? RUN_MAX : per_wide[COUNTER_BITS-1:0];
`else
      run_inc  = run_q + RUN_ONE;
      per_sum  = th_q + run_q;
`endif
      run_d    = run_inc;

      if (64'(cnt_q) >= half_m1) begin
        freq_d = ~freq_q;
        cnt_d  = '0;
      end

      // The level before the first edge is partial, so only arm on it.
      if (edge_det) begin
        run_d  = RUN_ONE;
        seen_d = 1'b1;
        if (seen_q) begin
          if (prev_q) begin
            th_d = run_q;
          end else begin
            tl_d  = run_q;
            per_d = per_sum;
          end
        end
      end
    end

    // Generator and measurement registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        freq_q <= 1'b0;
        prev_q <= 1'b0;
        seen_q <= 1'b0;
        run_q  <= '0;
        th_q   <= '0;
        tl_q   <= '0;
        per_q  <= '0;
      end else begin
        cnt_q  <= cnt_d;
        freq_q <= freq_d;
        prev_q <= freq_q;
        seen_q <= seen_d;
        run_q  <= run_d;
        th_q   <= th_d;
        tl_q   <= tl_d;
        per_q  <= per_d;
      end
    end

    assign freq_out[g]                               = freq_q;
    assign time_high[g*COUNTER_BITS +: COUNTER_BITS] = th_q;
    assign time_low[g*COUNTER_BITS +: COUNTER_BITS]  = tl_q;
    assign period[g*COUNTER_BITS +: COUNTER_BITS]    = per_q;
  end

endmodule

// File: tb/tb_freq_measure_array.sv
// Directed bench for freq_measure_array: default instance plus an 8-bit
// counter instance sharing the same stimulus.
module tb_freq_measure_array;
  localparam int NP = 4;
  localparam int IB = 8;
  localparam int CB = 32;
  localparam int W  = NP * IB;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic shift_in = 1'b0;
  logic load = 1'b0;

  logic [W-1:0]     data_out, data_out8;
  logic [NP-1:0]    freq_out, freq_out8;
  logic [NP*CB-1:0] time_high, time_low, period;
  logic [NP*8-1:0]  time_high8, time_low8, period8;

  int checks = 0;
  int failures = 0;

  // Clock
  always #5 clk = ~clk;

  freq_measure_array dut (
    .clk(clk), .reset_n(reset_n), .shift_in(shift_in), .load(load),
    .data_out(data_out), .freq_out(freq_out),
    .time_high(time_high), .time_low(time_low), .period(period)
  );

  freq_measure_array #(.COUNTER_BITS(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .shift_in(shift_in), .load(load),
    .data_out(data_out8), .freq_out(freq_out8),
    .time_high(time_high8), .time_low(time_low8), .period(period8)
  );

  // Driver: shift n bits of w, MSB first, one per negedge.
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      shift_in = w[i];
      load = 1'b0;
    end
  endtask

  // Driver: one load pulse; returns at the negedge after the load edge.
  task automatic pulse_load();
    @(negedge clk);
    shift_in = 1'b0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (data_out !== '0) begin failures++; $display("FAIL rst_data_out got %0h exp 0", data_out); end
    checks++;
    if (freq_out !== '0) begin failures++; $display("FAIL rst_freq_out got %0h exp 0", freq_out); end
    checks++;
    if ((time_high | time_low | period) !== '0) begin
      failures++; $display("FAIL rst_meas got th=%0h tl=%0h per=%0h exp 0", time_high, time_low, period);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_shift_load();
    logic [31:0] w;
    int bad;
    w = 32'hFF80_0001;
    bad = 0;
    for (int i = 31; i >= 0; i--) begin
      @(negedge clk);
      if (data_out !== '0) bad++;
      shift_in = w[i];
    end
    @(negedge clk);
    if (data_out !== '0) bad++;
    shift_in = 1'b0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL shift_hold got %0d changes exp 0", bad); end
    checks++;
    if (data_out !== 32'hFF80_0001) begin failures++; $display("FAIL load_data got %0h exp ff800001", data_out); end
  endtask

  task automatic test_long_run();
    logic [31:0] exp_h [NP];
    logic [7:0]  exp8;
    exp_h = '{32'd24902, 32'd25000, 32'd12452, 32'd1};
`ifdef FREQ_MEASURE_SATURATE_EN
    exp8 = 8'd255;
`else
    exp8 = 8'd168;
`endif
    repeat (80000) @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (time_high[i*CB +: CB] !== exp_h[i]) begin
        failures++; $display("FAIL long_th pix%0d got %0d exp %0d", i, time_high[i*CB +: CB], exp_h[i]);
      end
      checks++;
      if (time_low[i*CB +: CB] !== exp_h[i]) begin
        failures++; $display("FAIL long_tl pix%0d got %0d exp %0d", i, time_low[i*CB +: CB], exp_h[i]);
      end
      checks++;
      if (period[i*CB +: CB] !== 2 * exp_h[i]) begin
        failures++; $display("FAIL long_per pix%0d got %0d exp %0d", i, period[i*CB +: CB], 2 * exp_h[i]);
      end
    end
    checks++;
    if (time_high8[15:8] !== exp8) begin
      failures++; $display("FAIL cnt8_th got %0d exp %0d", time_high8[15:8], exp8);
    end
  endtask

  task automatic test_freq_change();
    shift_bits(32'hFFFF_0001, 32);
    pulse_load();
    checks++;
    if (data_out !== 32'hFFFF_0001) begin failures++; $display("FAIL chg_data got %0h exp ffff0001", data_out); end
    checks++;
    if (freq_out[2] !== 1'b0) begin failures++; $display("FAIL chg_before got %0b exp 0", freq_out[2]); end
    @(negedge clk);
    checks++;
    if (freq_out[2] !== 1'b1) begin failures++; $display("FAIL chg_toggle got %0b exp 1", freq_out[2]); end
    repeat (20) @(negedge clk);
    checks++;
    if (time_high[2*CB +: CB] !== 32'd1 || time_low[2*CB +: CB] !== 32'd1 || period[2*CB +: CB] !== 32'd2) begin
      failures++;
      $display("FAIL chg_meas got th=%0d tl=%0d per=%0d exp 1 1 2",
               time_high[2*CB +: CB], time_low[2*CB +: CB], period[2*CB +: CB]);
    end
  endtask

  task automatic test_reset_mid();
    shift_bits(32'h0000_03FF, 10);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (data_out !== '0 || freq_out !== '0) begin
      failures++; $display("FAIL midrst_out got data=%0h freq=%0h exp 0", data_out, freq_out);
    end
    checks++;
    if ((time_high | time_low | period) !== '0) begin
      failures++; $display("FAIL midrst_meas got th=%0h tl=%0h per=%0h exp 0", time_high, time_low, period);
    end
    checks++;
    if (data_out8 !== '0 || (time_high8 | time_low8 | period8) !== '0) begin
      failures++; $display("FAIL midrst_cnt8 got data=%0h th=%0h exp 0", data_out8, time_high8);
    end
    shift_in = 1'b0;
    load = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_post_reset_latch();
    shift_bits(32'h0000_00FF, 8);
    pulse_load();
    checks++;
    if (data_out !== 32'h0000_00FF) begin failures++; $display("FAIL post_data got %0h exp ff", data_out); end
    checks++;
    if (freq_out[0] !== 1'b0) begin failures++; $display("FAIL post_f0 got %0b exp 0", freq_out[0]); end
    @(negedge clk);
    checks++;
    if (freq_out[0] !== 1'b1 || time_high[CB-1:0] !== '0) begin
      failures++; $display("FAIL post_edge1 got f=%0b th=%0d exp 1 0", freq_out[0], time_high[CB-1:0]);
    end
    @(negedge clk);
    checks++;
    if (time_high[CB-1:0] !== '0 || time_low[CB-1:0] !== '0 || period[CB-1:0] !== '0) begin
      failures++;
      $display("FAIL post_first_nolatch got th=%0d tl=%0d per=%0d exp 0 0 0",
               time_high[CB-1:0], time_low[CB-1:0], period[CB-1:0]);
    end
    @(negedge clk);
    checks++;
    if (time_high[CB-1:0] !== 32'd1) begin failures++; $display("FAIL post_th got %0d exp 1", time_high[CB-1:0]); end
    @(negedge clk);
    checks++;
    if (time_low[CB-1:0] !== 32'd1 || period[CB-1:0] !== 32'd2) begin
      failures++; $display("FAIL post_tl_per got tl=%0d per=%0d exp 1 2", time_low[CB-1:0], period[CB-1:0]);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (time_high[CB-1:0] !== 32'd1 || time_low[CB-1:0] !== 32'd1 || period[CB-1:0] !== 32'd2) begin
      failures++;
      $display("FAIL post_50 got th=%0d tl=%0d per=%0d exp 1 1 2",
               time_high[CB-1:0], time_low[CB-1:0], period[CB-1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_shift_load();
    test_long_run();
    test_freq_change();
    test_reset_mid();
    test_post_reset_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_measure_array.md
FREQ_MEASURE_ARRAY -- requirements
Module: freq_measure_array

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 4, number of pixel channels.
REQ-002 SHALL have parameter INPUT_BITS, default 8, bits per pixel.
REQ-003 SHALL have parameter COUNTER_BITS, default 32, width of each measurement word.
REQ-004 SHALL have parameter CLOCK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-005 SHALL have parameter LOW_FREQ, default 1_000, output frequency in Hz for pixel value 0.
REQ-006 SHALL have parameter HIGH_FREQ, default 20_000_000, output frequency in Hz for pixel value 2^INPUT_BITS-1.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 shift_in  input  1  serial pixel data, MSB of line first.
REQ-010 load  input  1  transfer shift register to data_out.
REQ-011 data_out  output  NUM_PIXELS*INPUT_BITS  loaded line; pixel i = data_out[i*INPUT_BITS +: INPUT_BITS].
REQ-012 freq_out  output  NUM_PIXELS  per-pixel generated square wave.
REQ-013 time_high, time_low, period  output  NUM_PIXELS*COUNTER_BITS each  per-pixel measured cycles; pixel i at [i*COUNTER_BITS +: COUNTER_BITS].

Function
REQ-014 Shift stage: when load=0, internal register SHALL shift left one bit per cycle, shift_in entering bit 0; data_out unchanged.
REQ-015 When load=1, data_out SHALL take the internal register value on that edge; internal register SHALL hold (no shift).
REQ-016 After WIDTH=NUM_PIXELS*INPUT_BITS shift cycles of bits b[WIDTH-1]..b[0] then one load cycle, data_out SHALL equal b.
REQ-017 Generator: per pixel, H_LOW = CLOCK_FREQ/(2*LOW_FREQ), H_HIGH = max(1, CLOCK_FREQ/(2*HIGH_FREQ)), integer truncation at elaboration.
REQ-018 Half-period for pixel value v SHALL be H(v) = H_LOW - ((H_LOW-H_HIGH)*v)/(2^INPUT_BITS-1), truncated; defaults give H(0)=25000, H(128)=12452, H(255)=1.
REQ-019 Generator counter SHALL increment each cycle; when count >= H(v)-1, freq_out SHALL toggle and count SHALL clear to 0; each level therefore lasts H(v) cycles.
REQ-020 A change of v SHALL take effect on the comparison in the same cycle without resetting the counter; a count already >= new H(v)-1 toggles next edge.
REQ-021 Measurement: per pixel, registered prev of freq_out and run-length counter; when freq_out != prev, an edge is detected, run SHALL reload to 1; otherwise run increments.
REQ-022 On falling edge (prev=1), time_high SHALL take run; on rising edge (prev=0), time_low SHALL take run and period SHALL take time_high + run.
REQ-023 The level preceding the first edge after reset is partial and SHALL NOT be latched; latching starts from the second edge.
REQ-024 Outputs hold between latches; latency from freq_out edge to updated measurement = 1 cycle.

Reset
REQ-025 reset_n low SHALL asynchronously clear internal shift register, data_out, freq_out, generator counters, prev, run, first-edge flags, time_high, time_low, period to 0.
REQ-026 Reset mid-line SHALL discard partial shift data; after release, operation resumes from the zero state.

Configuration
REQ-027 With FREQ_MEASURE_SATURATE_EN defined, run and period SHALL saturate at 2^COUNTER_BITS-1.
REQ-028 Without FREQ_MEASURE_SATURATE_EN, run and period SHALL wrap modulo 2^COUNTER_BITS.

Verification
REQ-029 Shift 32 bits 0xFF80_0001 MSB first, pulse load -> data_out=0xFF800001; data_out unchanged during preceding shifts.
REQ-030 Pixel value 0xFF, 50 cycles after load -> time_high=1, time_low=1, period=2.
REQ-031 Pixel value 0x00, run 120000 cycles -> time_high=25000, time_low=25000, period=50000.
REQ-032 Pixel value 0x80 -> time_high=time_low=12452, period=24904; change to 0xFF mid-level -> toggle next edge, then period=2.
REQ-033 Assert reset_n low mid-shift and mid-measurement -> all outputs 0 immediately; first post-reset latch only after second edge.
REQ-034 COUNTER_BITS=8, pixel 0x00: with FREQ_MEASURE_SATURATE_EN -> time_high=255; without -> time_high=25000 mod 256=168.
